// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : freq_meter_pkg
//  Description : Shared types and sizing helpers for the frequency meter.
//  Revision    : 1.0  initial release
// ============================================================================
package freq_meter_pkg;

    // Measurement controller states
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // Gate counter width: clog2 of the window length, never narrower than 1 bit
    function automatic int gate_cnt_width(input int gate_cycles);
        return (gate_cycles <= 1) ? 1 : $clog2(gate_cycles);
    endfunction

    // Largest value representable in a w-bit unsigned counter (w <= 32)
    function automatic int unsigned sat_max(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_det
//  Description : Multi-flop synchronizer for an asynchronous input followed by
//                a registered rising-edge detector. The pulse on 'rise'
//                appears SYNC_STAGES+1 cycles after the input is sampled high.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;

    // Synchronizer chain, one-cycle history of its output and the edge flop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : freq_meter
//  Description : Counts rising edges of an asynchronous signal over a gate
//                window of exactly GATE_CYCLES clocks and reports the count
//                with a one-cycle valid strobe. Counting saturates and flags
//                overflow. Define FREQ_METER_CONTINUOUS_EN to make windows
//                run back-to-back forever after the first start.
//  Revision    : 1.0  initial release
// ============================================================================
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] count_out,
    output logic             valid,
    output logic             overflow
);

    localparam int                  c_GATE_W    = gate_cnt_width(GATE_CYCLES);
    localparam logic [c_GATE_W-1:0] c_GATE_LOAD = c_GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = CNT_W'(sat_max(CNT_W));
`ifdef FREQ_METER_CONTINUOUS_EN
    localparam bit                  c_CONTINUOUS = 1'b1;
`else
    localparam bit                  c_CONTINUOUS = 1'b0;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_GATE_W-1:0] r_gate_cnt;
    logic [CNT_W-1:0]    r_edge_cnt;
    logic                r_ovf;
    logic [CNT_W-1:0]    r_count_out;
    logic                r_overflow;
    logic                r_valid;

    logic                w_edge;
    logic                w_gate_done;
    logic                w_busy;
    logic                w_load;
    logic                w_restart;
    logic [CNT_W-1:0]    w_cnt_upd;
    logic                w_ovf_upd;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk   (clk),
        .reset (reset),
        .d     (sig_in),
        .rise  (w_edge)
    );

    assign w_gate_done = (r_state == MEASURE) && (r_gate_cnt == '0);

    // Saturating edge count including this cycle's edge
    always_comb begin
        w_cnt_upd = r_edge_cnt;
        w_ovf_upd = r_ovf;
        if (w_edge) begin
            if (r_edge_cnt == c_CNT_MAX) begin
                w_ovf_upd = 1'b1;
            end else begin
                w_cnt_upd = r_edge_cnt + CNT_W'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: continuous builds never leave MEASURE on their own
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (w_gate_done && !c_CONTINUOUS) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State-decoded controls: busy flag, window load on start, auto restart
    always_comb begin
        w_busy    = (r_state == MEASURE);
        w_load    = (r_state == IDLE) && start;
        w_restart = w_gate_done && c_CONTINUOUS;
    end

    // Window datapath; the final cycle's edge is folded into the result and,
    // when restarting, the next window begins from zero on the following cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gate_cnt  <= '0;
            r_edge_cnt  <= '0;
            r_ovf       <= 1'b0;
            r_count_out <= '0;
            r_overflow  <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_load || w_restart) begin
                r_gate_cnt <= c_GATE_LOAD;
                r_edge_cnt <= '0;
                r_ovf      <= 1'b0;
            end else if (r_state == MEASURE) begin
                r_gate_cnt <= r_gate_cnt - c_GATE_W'(1);
                r_edge_cnt <= w_cnt_upd;
                r_ovf      <= w_ovf_upd;
            end
            if (w_gate_done) begin
                r_count_out <= w_cnt_upd;
                r_overflow  <= w_ovf_upd;
                r_valid     <= 1'b1;
            end
        end
    end

    assign busy      = w_busy;
    assign count_out = r_count_out;
    assign valid     = r_valid;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_freq_meter
//  Description : Self-checking bench for freq_meter. Three instances (long
//                window, narrow counter, one-cycle window) share clock, reset
//                and sig_in. Expected counts come from the recorded history
//                of sig_in: a rising edge of the pin counts in the cycle it
//                emerges from the synchronizer (SYNC_STAGES+1 cycles later).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_freq_meter;

    localparam int c_SYNC = 2;
    localparam int c_LAT  = c_SYNC + 1;
    localparam int c_GA   = 100;
    localparam int c_GC   = 1;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        sig_in   = 1'b0;
    logic [2:0]  st       = '0;
    logic [2:0]  busy_v;
    logic [2:0]  valid_v;
    logic [2:0]  ovf_v;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    logic [15:0] cnt_c;

    int          cyc      = 0;
    bit          hist [0:65535];
    int          checks   = 0;
    int          failures = 0;

    int          sig_mode  = 0;
    int          period    = 10;
    int          phase     = 0;
    int          pulse_cyc = -100;
    logic        sig_const = 1'b0;

    freq_meter #(.GATE_CYCLES(c_GA), .CNT_W(16), .SYNC_STAGES(c_SYNC)) u_a (
        .clk(clk), .reset(reset), .sig_in(sig_in), .start(st[0]), .busy(busy_v[0]),
        .count_out(cnt_a), .valid(valid_v[0]), .overflow(ovf_v[0]));

    freq_meter #(.GATE_CYCLES(c_GA), .CNT_W(4), .SYNC_STAGES(c_SYNC)) u_b (
        .clk(clk), .reset(reset), .sig_in(sig_in), .start(st[1]), .busy(busy_v[1]),
        .count_out(cnt_b), .valid(valid_v[1]), .overflow(ovf_v[1]));

    freq_meter #(.GATE_CYCLES(c_GC), .CNT_W(16), .SYNC_STAGES(c_SYNC)) u_c (
        .clk(clk), .reset(reset), .sig_in(sig_in), .start(st[2]), .busy(busy_v[2]),
        .count_out(cnt_c), .valid(valid_v[2]), .overflow(ovf_v[2]));

    always #5 clk = ~clk;

    // Record what the synchronizer sees each cycle; reset clears its view
    always @(posedge clk) begin
        hist[cyc] = reset ? 1'b0 : sig_in;
        cyc = cyc + 1;
    end

    // sig_in pattern generator, updated just after each rising edge
    always @(posedge clk) begin
        #1;
        case (sig_mode)
            0:       sig_in = sig_const;
            1:       sig_in = (((cyc + phase) % period) == 0);
            2:       sig_in = (((cyc / 2) % 2) == 1);
            3:       sig_in = ($urandom_range(0, 3) == 0);
            default: sig_in = (cyc == pulse_cyc);
        endcase
    end

    // Number of detected rising edges in cycles a..b inclusive
    function automatic int edges_in(input int a, input int b);
        int n = 0;
        for (int m = a; m <= b; m++) begin
            if ((m - c_LAT - 1 >= 0) && hist[m - c_LAT] && !hist[m - c_LAT - 1]) n++;
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
    endtask

    task automatic wait_until(input int tt);
        while (cyc < tt) tick();
    endtask

    task automatic start_pulse(input int which, output int t);
        tick();
        st[which] = 1'b1;
        t = cyc;
        tick();
        st[which] = 1'b0;
    endtask

    task automatic wait_valid(input int which, input int limit, output int vc);
        vc = -1;
        for (int i = 0; i < limit && vc < 0; i++) begin
            @(negedge clk);
            if (valid_v[which]) vc = cyc;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (busy_v !== 3'b000) begin failures++; $display("FAIL reset_busy: got %b expected 000", busy_v); end
        checks++; if (valid_v !== 3'b000) begin failures++; $display("FAIL reset_valid: got %b expected 000", valid_v); end
        checks++; if (ovf_v !== 3'b000) begin failures++; $display("FAIL reset_overflow: got %b expected 000", ovf_v); end
        checks++; if (cnt_a !== 16'd0 || cnt_b !== 4'd0 || cnt_c !== 16'd0) begin
            failures++; $display("FAIL reset_count: got %0d/%0d/%0d expected 0/0/0", cnt_a, cnt_b, cnt_c);
        end
    endtask

    task automatic test_pulse10();
        int t, vc, nb, n;
        do_reset();
        sig_mode = 1; period = 10; phase = $urandom_range(0, 9);
        repeat (8) tick();
        start_pulse(0, t);
        nb = 0; vc = -1;
        for (int i = 0; i < c_GA + 20 && vc < 0; i++) begin
            @(negedge clk);
            if (valid_v[0]) vc = cyc;
            else if (busy_v[0]) nb++;
        end
        n = edges_in(t + 1, t + c_GA);
        checks++; if (vc !== t + c_GA + 1) begin failures++; $display("FAIL pulse10_valid_cycle: got %0d expected %0d", vc, t + c_GA + 1); end
        checks++; if (nb !== c_GA) begin failures++; $display("FAIL pulse10_busy_cycles: got %0d expected %0d", nb, c_GA); end
        checks++; if (cnt_a !== 16'(n)) begin failures++; $display("FAIL pulse10_count: got %0d expected %0d", cnt_a, n); end
        checks++; if (ovf_v[0] !== 1'b0) begin failures++; $display("FAIL pulse10_overflow: got %b expected 0", ovf_v[0]); end
    endtask

    task automatic test_saturate();
        int t, vc, n;
        do_reset();
        sig_mode = 2;
        repeat (6) tick();
        start_pulse(1, t);
        wait_valid(1, c_GA + 10, vc);
        n = edges_in(t + 1, t + c_GA);
        checks++; if (vc !== t + c_GA + 1) begin failures++; $display("FAIL sat_valid_cycle: got %0d expected %0d", vc, t + c_GA + 1); end
        checks++; if (cnt_b !== 4'((n > 15) ? 15 : n)) begin failures++; $display("FAIL sat_count: got %0d expected %0d", cnt_b, (n > 15) ? 15 : n); end
        checks++; if (ovf_v[1] !== (n > 15)) begin failures++; $display("FAIL sat_overflow: got %b expected %b", ovf_v[1], (n > 15)); end
        sig_mode = 0; sig_const = 1'b0;
        repeat (6) tick();
`ifdef FREQ_METER_CONTINUOUS_EN
        do_reset();
`endif
        start_pulse(1, t);
        wait_valid(1, c_GA + 10, vc);
        n = edges_in(t + 1, t + c_GA);
        checks++; if (vc !== t + c_GA + 1) begin failures++; $display("FAIL quiet_valid_cycle: got %0d expected %0d", vc, t + c_GA + 1); end
        checks++; if (cnt_b !== 4'(n) || ovf_v[1] !== 1'b0) begin
            failures++; $display("FAIL quiet_count: got %0d ovf %b expected %0d ovf 0", cnt_b, ovf_v[1], n);
        end
    endtask

    task automatic test_held_high();
        int t, vc, n;
        sig_mode = 0; sig_const = 1'b1;
        repeat (3) tick();
        do_reset();
        repeat (6) tick();
        start_pulse(0, t);
        wait_valid(0, c_GA + 10, vc);
        n = edges_in(t + 1, t + c_GA);
        checks++; if (vc !== t + c_GA + 1) begin failures++; $display("FAIL held_valid_cycle: got %0d expected %0d", vc, t + c_GA + 1); end
        checks++; if (cnt_a !== 16'(n)) begin failures++; $display("FAIL held_count: got %0d expected %0d", cnt_a, n); end
        sig_const = 1'b0;
    endtask

    task automatic test_last_cycle();
        int t, vc, n;
        do_reset();
        sig_mode = 4;
        for (int k = 0; k < 2; k++) begin
`ifdef FREQ_METER_CONTINUOUS_EN
            if (k == 1) do_reset();
`endif
            pulse_cyc = cyc + 1 + c_GA - c_LAT + k;
            start_pulse(0, t);
            wait_valid(0, c_GA + 10, vc);
            n = edges_in(t + 1, t + c_GA);
            checks++; if (vc !== t + c_GA + 1) begin failures++; $display("FAIL last%0d_valid_cycle: got %0d expected %0d", k, vc, t + c_GA + 1); end
            checks++; if (cnt_a !== 16'(n)) begin failures++; $display("FAIL last%0d_count: got %0d expected %0d", k, cnt_a, n); end
            repeat (4) tick();
        end
    endtask

    task automatic test_gate1();
        int t, tt, vc, n;
        do_reset();
        sig_mode = 4;
        for (int k = 0; k < 3; k++) begin
`ifdef FREQ_METER_CONTINUOUS_EN
            do_reset();
`endif
            tt = cyc + 6;
            pulse_cyc = tt + 1 - c_LAT + (k - 1);
            wait_until(tt - 1);
            start_pulse(2, t);
            wait_valid(2, 10, vc);
            n = edges_in(t + 1, t + c_GC);
            checks++; if (vc !== t + c_GC + 1) begin failures++; $display("FAIL gate1_%0d_valid_cycle: got %0d expected %0d", k, vc, t + c_GC + 1); end
            checks++; if (cnt_c !== 16'(n)) begin failures++; $display("FAIL gate1_%0d_count: got %0d expected %0d", k, cnt_c, n); end
            repeat (4) tick();
        end
    endtask

    task automatic test_start_spam();
        int t, vc, nv, n;
        logic [15:0] cval;
        do_reset();
        sig_mode = 3;
        tick();
        st[0] = 1'b1;
        t = cyc;
        nv = 0; vc = -1; cval = '0;
        while (cyc < t + c_GA + 8) begin
            @(negedge clk);
            if (valid_v[0]) begin nv++; vc = cyc; cval = cnt_a; end
            @(posedge clk);
            #1;
            if (cyc > t + c_GA) st[0] = 1'b0;
        end
        n = edges_in(t + 1, t + c_GA);
        checks++; if (nv !== 1) begin failures++; $display("FAIL spam_valid_pulses: got %0d expected 1", nv); end
        checks++; if (vc !== t + c_GA + 1) begin failures++; $display("FAIL spam_valid_cycle: got %0d expected %0d", vc, t + c_GA + 1); end
        checks++; if (cval !== 16'(n)) begin failures++; $display("FAIL spam_count: got %0d expected %0d", cval, n); end
    endtask

    task automatic test_back_to_back();
        int t, vc, vc2, a, n, exp_vc;
        logic exp_busy;
        do_reset();
        sig_mode = 1; period = $urandom_range(3, 9); phase = $urandom_range(0, 8);
        repeat (5) tick();
        start_pulse(0, t);
        wait_valid(0, c_GA + 10, vc);
        st[0] = 1'b1;
`ifdef FREQ_METER_CONTINUOUS_EN
        exp_busy = 1'b1; exp_vc = vc + c_GA; a = vc;
`else
        exp_busy = 1'b0; exp_vc = vc + c_GA + 1; a = vc + 1;
`endif
        checks++; if (busy_v[0] !== exp_busy) begin failures++; $display("FAIL b2b_busy_at_valid: got %b expected %b", busy_v[0], exp_busy); end
        tick();
        st[0] = 1'b0;
        @(negedge clk);
        checks++; if (busy_v[0] !== 1'b1 || valid_v[0] !== 1'b0) begin
            failures++; $display("FAIL b2b_after_valid: got busy %b valid %b expected busy 1 valid 0", busy_v[0], valid_v[0]);
        end
        wait_valid(0, c_GA + 10, vc2);
        n = edges_in(a, a + c_GA - 1);
        checks++; if (vc2 !== exp_vc) begin failures++; $display("FAIL b2b_valid_cycle: got %0d expected %0d", vc2, exp_vc); end
        checks++; if (cnt_a !== 16'(n)) begin failures++; $display("FAIL b2b_count: got %0d expected %0d", cnt_a, n); end
    endtask

    task automatic test_reset_mid();
        int t, t2, vc, nv;
        do_reset();
        sig_mode = 3;
        start_pulse(0, t);
        wait_valid(0, c_GA + 10, vc);
`ifdef FREQ_METER_CONTINUOUS_EN
        t2 = vc - 1;
        tick();
`else
        start_pulse(0, t2);
`endif
        wait_until(t2 + 50);
        reset = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (busy_v[0] !== 1'b0 || valid_v[0] !== 1'b0) begin
            failures++; $display("FAIL midreset_flags: got busy %b valid %b expected 0 0", busy_v[0], valid_v[0]);
        end
        checks++; if (cnt_a !== 16'd0 || ovf_v[0] !== 1'b0) begin
            failures++; $display("FAIL midreset_result: got count %0d ovf %b expected 0 0", cnt_a, ovf_v[0]);
        end
        repeat (3) tick();
        reset = 1'b0;
        nv = 0;
        for (int i = 0; i < 2 * c_GA; i++) begin
            @(negedge clk);
            if (valid_v[0]) nv++;
        end
        checks++; if (nv !== 0 || busy_v[0] !== 1'b0) begin
            failures++; $display("FAIL midreset_no_valid: got %0d valids busy %b expected 0 valids busy 0", nv, busy_v[0]);
        end
    endtask

`ifdef FREQ_METER_CONTINUOUS_EN
    task automatic test_continuous();
        int t, vc, n, sum, total;
        do_reset();
        sig_mode = 1; period = 5; phase = $urandom_range(0, 4);
        repeat (4) tick();
        start_pulse(0, t);
        sum = 0;
        for (int w = 0; w < 10; w++) begin
            if (w == 3) st[0] = 1'b1;
            if (w == 4) st[0] = 1'b0;
            wait_valid(0, c_GA + 5, vc);
            n = edges_in(t + 1 + w * c_GA, t + (w + 1) * c_GA);
            checks++; if (vc !== t + (w + 1) * c_GA + 1) begin failures++; $display("FAIL cont%0d_valid_cycle: got %0d expected %0d", w, vc, t + (w + 1) * c_GA + 1); end
            checks++; if (cnt_a !== 16'(n)) begin failures++; $display("FAIL cont%0d_count: got %0d expected %0d", w, cnt_a, n); end
            sum = sum + int'(cnt_a);
        end
        total = edges_in(t + 1, t + 10 * c_GA);
        checks++; if (sum !== total) begin failures++; $display("FAIL cont_sum: got %0d expected %0d", sum, total); end
    endtask
`endif

    initial begin
        test_reset();
        test_pulse10();
        test_saturate();
        test_held_high();
        test_last_cycle();
        test_gate1();
        test_start_spam();
        test_back_to_back();
        test_reset_mid();
`ifdef FREQ_METER_CONTINUOUS_EN
        test_continuous();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
`default_nettype wire
